ffdiv: RTL

- Multi-cycle restoring divider. It is the inverse of the pipelined multiply-accumulate datapath: it takes a 2*BITS-bit value n and a BITS-bit divisor d.
- Returns quotient q and remainder r such that n = q*d + r, with r < d.
- Valid/ready handshake on both sides. Resolves one quotient bit per cycle.
- Sits downstream of the MAC block to recover factors and residues for check and normalisation paths.

---
 rtl/ffdiv_if.sv | 20 ++
 rtl/ffdiv.sv | 73 +++++++
 2 files changed

// File: rtl/ffdiv_if.sv
// ffdiv_if: request/result handshake bundle for the ffdiv divider.
// The dz port exists only when FFDIV_DZ_FLAG_EN is defined.
interface ffdiv_if #(parameter int BITS = 4);
  logic [2*BITS-1:0] n;
  logic [BITS-1:0]   d;
  logic              in_valid;
  logic              in_ready;
  logic [2*BITS-1:0] q;
  logic [BITS-1:0]   r;
  logic              out_valid;
  logic              out_ready;
`ifdef FFDIV_DZ_FLAG_EN
  logic              dz;
  modport master (output n, d, in_valid, out_ready, input in_ready, q, r, out_valid, dz);
  modport slave  (input n, d, in_valid, out_ready, output in_ready, q, r, out_valid, dz);
`else
  modport master (output n, d, in_valid, out_ready, input in_ready, q, r, out_valid);
  modport slave  (input n, d, in_valid, out_ready, output in_ready, q, r, out_valid);
`endif
endinterface

// File: rtl/ffdiv.sv
// ffdiv: multi-cycle restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional FFDIV_DZ_FLAG_EN adds a registered divide-by-zero flag (dz).
module ffdiv #(
  parameter int BITS = 4
) (
  input logic    clk,
  input logic    rst,
  ffdiv_if.slave bus
);
  localparam int W  = 2 * BITS;
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]      r_state;
  logic [BITS-1:0] r_pr;
  logic [W-1:0]    r_qs;
  logic [BITS-1:0] r_d;
  logic [CW-1:0]   r_cnt;
  logic [BITS:0]   w_sh;
  logic [BITS-1:0] w_dif;
  logic            w_ge;
  // w_sh carries the guard bit so the compare cannot overflow for d near 2^BITS-1
  assign w_sh  = {r_pr, r_qs[W-1]};
  assign w_ge  = w_sh >= {1'b0, r_d};
  assign w_dif = w_sh[BITS-1:0] - r_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pr    <= '0;
      r_qs    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.in_valid) begin
        r_d   <= bus.d;
        r_cnt <= CW'(W);
        if (bus.d == '0) begin
          r_state <= S_DONE;
          r_qs    <= '1;
          r_pr    <= bus.n[BITS-1:0];
        end else begin
          r_state <= S_RUN;
          r_qs    <= bus.n;
          r_pr    <= '0;
        end
      end
    end else if (r_state == S_RUN) begin
      r_pr    <= w_ge ? w_dif : w_sh[BITS-1:0];
      r_qs    <= {r_qs[W-2:0], w_ge};
      r_cnt   <= r_cnt - CW'(1);
      r_state <= (r_cnt == CW'(1)) ? S_DONE : S_RUN;
    end else if (bus.out_ready) begin
      r_state <= S_IDLE;
    end
  end
`ifdef FFDIV_DZ_FLAG_EN
  logic r_dz;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_dz <= 1'b0;
    else if (r_state == S_IDLE && bus.in_valid)
      r_dz <= bus.d == '0;
    else if (r_state != S_IDLE && r_state != S_RUN && bus.out_ready)
      r_dz <= 1'b0;
  end
  assign bus.dz = r_dz;
`endif
  assign bus.in_ready  = r_state == S_IDLE;
  assign bus.out_valid = r_state == S_DONE;
  assign bus.q         = r_qs;
  assign bus.r         = r_pr;
endmodule
